// File: rtl/noc_pkg.sv
// Shared flit types, header field layout and arbiter state encoding for the
// NOC router output side.
package noc_pkg;

   typedef logic [15:0] flit_t;

   localparam int unsigned LEN_LSB = 0;
   localparam int unsigned LEN_W   = 4;

   typedef enum logic {
      ARB_IDLE,
      ARB_BODY
   } arb_state_t;

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational round-robin picker: first requester at or above ptr, wrapping
// N-1 -> 0. Returns the winner one-hot and encoded.
module noc_rr_arbiter #(
   parameter int unsigned N  = 5,
   parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] pi;

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      pi  = '0;
      for (int unsigned off = 0; off < N; off++) begin
         pi = IW'((32'(ptr) + off) % N);
         if (!any && req[pi]) begin
            any     = 1'b1;
            gnt[pi] = 1'b1;
            idx     = pi;
         end
      end
   end

endmodule

// File: rtl/noc_output_arbiter.sv
// Per-output wormhole switch allocator with round-robin header arbitration and
// downstream credit tracking. Define NOC_ARB_STATS_EN for packet/stall counters.
module noc_output_arbiter
   import noc_pkg::*;
#(
   parameter int unsigned N       = 5,
   parameter int unsigned CREDITS = 5,
   parameter int unsigned W       = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req_i,
   input  logic [N-1:0]   valid_i,
   input  logic [N*W-1:0] data_i,
   output logic [N-1:0]   shift_o,
   output logic [W-1:0]   data_o,
   output logic           valid_o,
   input  logic           credit_i,
   output logic [N-1:0]   grant_o,
   output logic [15:0]    pkt_count_o,
   output logic [15:0]    stall_count_o
);

   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = $clog2(CREDITS + 1);
   localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);
   localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

   arb_state_t       state, state_nxt;
   logic [IW-1:0]    ptr, owner, sel;
   logic [CW-1:0]    credits;
   logic [LEN_W-1:0] remaining, hdr_len;
   logic [N-1:0]     rr_gnt;
   logic [IW-1:0]    rr_idx;
   logic             rr_any;
   logic             send, last_flit, has_credit;
   logic [W-1:0]     flits [N];

   always_comb begin
      for (int unsigned i = 0; i < N; i++) flits[i] = data_i[i*W +: W];
   end

   // valid_i qualifies req_i so a stale header never wins an empty FIFO
   noc_rr_arbiter #(.N(N), .IW(IW)) u_rr (
      .req (req_i & valid_i),
      .ptr (ptr),
      .gnt (rr_gnt),
      .idx (rr_idx),
      .any (rr_any)
   );

   assign has_credit = (credits != '0);
   assign hdr_len    = flits[rr_idx][LEN_LSB +: LEN_W];

   always_comb begin
      state_nxt = state;
      shift_o   = '0;
      sel       = owner;
      last_flit = 1'b0;
      case (state)
         ARB_IDLE: begin
            if (rr_any && has_credit) begin
               shift_o   = rr_gnt;
               sel       = rr_idx;
               last_flit = (hdr_len == '0);
               if (!last_flit) state_nxt = ARB_BODY;
            end
         end
         ARB_BODY: begin
            if (valid_i[owner] && has_credit) begin
               shift_o[owner] = 1'b1;
               last_flit      = (remaining == LEN_W'(1));
               if (last_flit) state_nxt = ARB_IDLE;
            end
         end
         default: state_nxt = ARB_IDLE;
      endcase
   end

   assign send    = |shift_o;
   assign grant_o = (state == ARB_BODY) ? (N'(1) << owner) : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ARB_IDLE;
         ptr       <= '0;
         owner     <= '0;
         credits   <= CRED_MAX;
         remaining <= '0;
         valid_o   <= 1'b0;
         data_o    <= '0;
      end else begin
         state   <= state_nxt;
         valid_o <= send;
         if (send) data_o <= flits[sel];
         if (send && !credit_i)
            credits <= credits - 1'b1;
         else if (credit_i && !send && credits != CRED_MAX)
            credits <= credits + 1'b1;
         if (state == ARB_IDLE && send) begin
            ptr       <= (rr_idx == LAST_IDX) ? '0 : rr_idx + 1'b1;
            owner     <= rr_idx;
            remaining <= hdr_len;
         end else if (state == ARB_BODY && send) begin
            remaining <= remaining - 1'b1;
         end
      end
   end

`ifdef NOC_ARB_STATS_EN
   logic [15:0] pkt_cnt, stall_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         pkt_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (send && last_flit && pkt_cnt != '1) pkt_cnt <= pkt_cnt + 1'b1;
         if (state == ARB_BODY && valid_i[owner] && !has_credit && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

   assign pkt_count_o   = pkt_cnt;
   assign stall_count_o = stall_cnt;
`else
   assign pkt_count_o   = '0;
   assign stall_count_o = '0;
`endif

   a_shift_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(shift_o));
   a_shift_valid:  assert property (@(posedge clk) disable iff (rst) (shift_o & ~valid_i) == '0);
   a_send_credit:  assert property (@(posedge clk) disable iff (rst) !(send && !has_credit));
   a_credit_over:  assert property (@(posedge clk) disable iff (rst)
                                    !(credit_i && !send && credits == CRED_MAX));

endmodule
